bnn_top_core: RTL and testbench

Binary neural network classifier for 30×30 monochrome digit images. It takes one captured frame from the image-buffer front end, runs a two-layer XNOR/popcount network sequentially, and reports a 4-bit class (0–9) with a one-cycle completion strobe. It sits between the image buffer/interface FSM and the result display/UART path.

---
 rtl/bnn_pkg.sv | 72 +++++++
 rtl/bnn_xnor_popcount.sv | 20 ++
 rtl/bnn_top_core.sv | 103 ++++++++++
 tb/tb_bnn_top_core.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants, types, default trained weights and popcount helper for the
// binary neural network digit classifier.
package bnn_pkg;

    localparam int IMG_BITS = 900;
    localparam int N_HID    = 32;
    localparam int N_CLS    = 10;

    typedef logic [IMG_BITS-1:0]            img_t;
    typedef logic [N_HID-1:0][IMG_BITS-1:0] w1_t;
    typedef logic [N_HID-1:0][9:0]          t1_t;
    typedef logic [N_CLS-1:0][N_HID-1:0]    w2_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HIDDEN, S_OUTPUT, S_DONE, S_WAIT_LOW
    } state_t;

    function automatic logic [31:0] xs32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    // Weight tables are reproduced from a fixed xorshift seed so the trained set
    // can be regenerated bit-exactly by any tool that evaluates this package.
    function automatic w1_t gen_w1();
        w1_t         w;
        logic [31:0] s;
        logic [927:0] row;
        s = 32'h2545_F491;
        for (int i = 0; i < N_HID; i++) begin
            for (int k = 0; k < 29; k++) begin
                s = xs32(s);
                row[k*32 +: 32] = s;
            end
            w[i] = row[IMG_BITS-1:0];
        end
        return w;
    endfunction

    function automatic t1_t gen_t1();
        t1_t t;
        for (int i = 0; i < N_HID; i++)
            t[i] = 10'(440 + (i * 7) % 21);
        return t;
    endfunction

    function automatic w2_t gen_w2();
        w2_t         w;
        logic [31:0] s;
        s = 32'h9E37_79B9;
        for (int k = 0; k < N_CLS; k++) begin
            s = xs32(s);
            w[k] = s;
        end
        return w;
    endfunction

    localparam w1_t W1_DEFAULT = gen_w1();
    localparam t1_t T1_DEFAULT = gen_t1();
    localparam w2_t W2_DEFAULT = gen_w2();

    function automatic logic [10:0] popcount(input logic [1023:0] v);
        logic [10:0] c;
        c = '0;
        for (int i = 0; i < 1024; i++)
            c = c + 11'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR of two W-bit vectors followed by a popcount of the
// agreeing bit positions.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int W  = 32,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [CW-1:0] cnt
);

    logic [W-1:0] agree;

    // Held in a W-bit variable so the widening below zero-fills the upper bits.
    assign agree = ~(a ^ b);
    assign cnt   = CW'(popcount(1024'(agree)));

endmodule

// File: rtl/bnn_top_core.sv
// Two-layer XNOR/popcount classifier: one hidden neuron per cycle, then one
// output class per cycle, reporting the arg-max class with a done strobe.
module bnn_top_core #(
    parameter int CONV1_IMG_IN_SIZE = 30,
    parameter int CONV1_IC          = 1,
    parameter int N_HID             = 32,
    parameter int N_CLS             = 10,
    parameter logic [N_HID-1:0][CONV1_IMG_IN_SIZE*CONV1_IMG_IN_SIZE-1:0] W1 = bnn_pkg::W1_DEFAULT,
    parameter logic [N_HID-1:0][9:0]       T1 = bnn_pkg::T1_DEFAULT,
    parameter logic [N_CLS-1:0][N_HID-1:0] W2 = bnn_pkg::W2_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [CONV1_IMG_IN_SIZE*CONV1_IMG_IN_SIZE-1:0] conv1_img_in [0:CONV1_IC-1],
    input  logic data_in_ready,
    output logic [3:0] result,
    output logic data_out_ready
);
    import bnn_pkg::*;

    localparam int IMG_W = CONV1_IMG_IN_SIZE * CONV1_IMG_IN_SIZE;
    localparam int HCW   = $clog2(IMG_W + 1);
    localparam int OCW   = $clog2(N_HID + 1);
    localparam int IDXW  = $clog2(N_HID);
    localparam int CIW   = $clog2(N_CLS);

    state_t           state, state_nxt;
    logic [IMG_W-1:0] x;
    logic [N_HID-1:0] h;
    logic [IDXW-1:0]  hid_idx;
    logic [CIW-1:0]   cls_idx;
    logic [OCW-1:0]   best_score;
    logic [CIW-1:0]   best_idx, best_idx_nxt;
    logic [HCW-1:0]   hid_cnt;
    logic [OCW-1:0]   cls_cnt;
    logic             take;

    bnn_xnor_popcount #(.W(IMG_W), .CW(HCW)) u_hid (
        .a(x), .b(W1[hid_idx]), .cnt(hid_cnt)
    );

    bnn_xnor_popcount #(.W(N_HID), .CW(OCW)) u_out (
        .a(h), .b(W2[cls_idx]), .cnt(cls_cnt)
    );

    // Strict compare keeps the lowest class index on ties.
    assign take         = (cls_idx == '0) || (cls_cnt > best_score);
    assign best_idx_nxt = take ? cls_idx : best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (data_in_ready) state_nxt = S_HIDDEN;
            S_HIDDEN:   if (hid_idx == IDXW'(N_HID - 1)) state_nxt = S_OUTPUT;
            S_OUTPUT:   if (cls_idx == CIW'(N_CLS - 1)) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: if (!data_in_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign data_out_ready = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            h          <= '0;
            hid_idx    <= '0;
            cls_idx    <= '0;
            best_score <= '0;
            best_idx   <= '0;
            result     <= '0;
        end else begin
            case (state)
                S_IDLE: if (data_in_ready) begin
                    x          <= conv1_img_in[0];
                    h          <= '0;
                    hid_idx    <= '0;
                    cls_idx    <= '0;
                    best_score <= '0;
                    best_idx   <= '0;
                end
                S_HIDDEN: begin
                    h[hid_idx] <= (hid_cnt >= T1[hid_idx]);
                    hid_idx    <= hid_idx + IDXW'(1);
                end
                S_OUTPUT: begin
                    if (take) best_score <= cls_cnt;
                    best_idx <= best_idx_nxt;
                    cls_idx  <= cls_idx + CIW'(1);
                    if (cls_idx == CIW'(N_CLS - 1)) result <= best_idx_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_top_core.sv
// Self-checking bench: three classifier instances (default weights, tied output
// weights, class-7 selector) share stimulus and are compared to a bit-counting model.
module tb_bnn_top_core;
    import bnn_pkg::*;

    localparam w1_t W1_ONES = '1;
    localparam t1_t T1_450  = {32{10'd450}};
    localparam w2_t W2_EQ   = {10{32'hC3A5_0F96}};
    localparam w2_t W2_SEL7 = w2_t'(32'hFFFF_FFFF) << 224;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    img_t       img [0:0];
    logic [3:0] r_def, r_tie, r_sel;
    logic       d_def, d_tie, d_sel;
    int         total, bad;

    always #5 clk = ~clk;

    bnn_top_core u_def (
        .clk(clk), .rst_n(rst_n), .conv1_img_in(img), .data_in_ready(din),
        .result(r_def), .data_out_ready(d_def)
    );

    bnn_top_core #(.W2(W2_EQ)) u_tie (
        .clk(clk), .rst_n(rst_n), .conv1_img_in(img), .data_in_ready(din),
        .result(r_tie), .data_out_ready(d_tie)
    );

    bnn_top_core #(.W1(W1_ONES), .T1(T1_450), .W2(W2_SEL7)) u_sel (
        .clk(clk), .rst_n(rst_n), .conv1_img_in(img), .data_in_ready(din),
        .result(r_sel), .data_out_ready(d_sel)
    );

    // Reference: count agreeing bits directly, keep the first best class.
    function automatic logic [3:0] ref_cls(input img_t im, input w1_t w1, input t1_t t1,
                                           input w2_t w2);
        logic [31:0] hv;
        int agree, s, best, bi;
        for (int i = 0; i < 32; i++) begin
            agree = 0;
            for (int j = 0; j < 900; j++) if (im[j] == w1[i][j]) agree++;
            hv[i] = (agree >= int'(t1[i]));
        end
        best = -1;
        bi   = 0;
        for (int k = 0; k < 10; k++) begin
            s = 0;
            for (int j = 0; j < 32; j++) if (hv[j] == w2[k][j]) s++;
            if (s > best) begin best = s; bi = k; end
        end
        return 4'(bi);
    endfunction

    function automatic img_t rand_img();
        logic [927:0] t;
        for (int k = 0; k < 29; k++) t[k*32 +: 32] = $urandom;
        return t[899:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_results(input string nm, input img_t im);
        chk({nm, "_def"}, 32'(r_def), int'(ref_cls(im, W1_DEFAULT, T1_DEFAULT, W2_DEFAULT)));
        chk({nm, "_tie"}, 32'(r_tie), int'(ref_cls(im, W1_DEFAULT, T1_DEFAULT, W2_EQ)));
        chk({nm, "_sel"}, 32'(r_sel), int'(ref_cls(im, W1_ONES, T1_450, W2_SEL7)));
    endtask

    // Called just after a negedge; returns edges from start to strobe, -1 on timeout.
    task automatic run_one(input img_t im, input bit scramble, output int lat);
        img[0] = im;
        din    = 1'b1;
        lat    = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (scramble && n >= 5 && n <= 40) img[0] = rand_img();
            if (d_def) begin lat = n - 1; break; end
        end
        din = 1'b0;
    endtask

    typedef struct {
        img_t       img;
        logic [3:0] e_def, e_tie, e_sel;
    } vec_t;

    vec_t vecs [24];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, pulses;
        img_t im;
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        din    = 1'b0;
        img[0] = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", 32'({r_def, r_tie, r_sel}), 0);
        chk("reset_strobe", 32'({d_def, d_tie, d_sel}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0].img = '0;
        vecs[1].img = '1;
        vecs[2].img = {450{2'b10}};
        vecs[3].img = {{450{1'b1}}, {450{1'b0}}};
        for (int v = 4; v < 24; v++) vecs[v].img = rand_img();
        for (int v = 0; v < 24; v++) begin
            vecs[v].e_def = ref_cls(vecs[v].img, W1_DEFAULT, T1_DEFAULT, W2_DEFAULT);
            vecs[v].e_tie = ref_cls(vecs[v].img, W1_DEFAULT, T1_DEFAULT, W2_EQ);
            vecs[v].e_sel = ref_cls(vecs[v].img, W1_ONES, T1_450, W2_SEL7);
        end

        for (int v = 0; v < 24; v++) begin
            run_one(vecs[v].img, 1'b0, lat);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 42);
            chk($sformatf("vec%0d_def", v), 32'(r_def), int'(vecs[v].e_def));
            chk($sformatf("vec%0d_tie", v), 32'(r_tie), int'(vecs[v].e_tie));
            chk($sformatf("vec%0d_sel", v), 32'(r_sel), int'(vecs[v].e_sel));
            chk($sformatf("vec%0d_sync", v), 32'({d_tie, d_sel}), 3);
            repeat (3) @(negedge clk);
        end

        // Image changes mid-inference must not disturb the captured frame.
        im = rand_img();
        run_one(im, 1'b1, lat);
        chk("isolate_latency", 32'(lat), 42);
        chk_results("isolate", im);
        repeat (3) @(negedge clk);

        // Held request: exactly one strobe, then restart after a drop.
        im     = rand_img();
        img[0] = im;
        din    = 1'b1;
        lat    = -1;
        pulses = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (d_def) begin
                pulses++;
                if (lat < 0) lat = n - 1;
            end
        end
        chk("hold_latency", 32'(lat), 42);
        chk("hold_pulses", 32'(pulses), 1);
        chk_results("hold", im);
        din = 1'b0;
        repeat (2) @(negedge clk);
        im = rand_img();
        run_one(im, 1'b0, lat);
        chk("restart_latency", 32'(lat), 42);
        chk_results("restart", im);
        repeat (3) @(negedge clk);

        // Reset in the middle of an inference.
        run_one('1, 1'b0, lat);
        chk("pre_reset_sel", 32'(r_sel), 7);
        repeat (3) @(negedge clk);
        img[0] = rand_img();
        din    = 1'b1;
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        din   = 1'b0;
        #1;
        chk("midreset_result", 32'({r_def, r_tie, r_sel}), 0);
        chk("midreset_strobe", 32'({d_def, d_tie, d_sel}), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (d_def || d_tie || d_sel) pulses++;
        end
        chk("postreset_no_strobe", 32'(pulses), 0);
        im = rand_img();
        run_one(im, 1'b0, lat);
        chk("postreset_latency", 32'(lat), 42);
        chk_results("postreset", im);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
